battle_link_rx: RTL
===================

// Module: battle_link_rx
// PURPOSE
//  Receive stage of the board-to-board battle link; consumes the opponent's con_in_* connector bus.
//  - Synchronises the bus into clk.
//  - Qualifies frames on remote sync-strobe edges and commits only stable, legal frames.
//  - Emits the opponent's status, score and KO count, plus single-cycle bomb/KO event pulses.
//  - Consumers: the game core (garbage injection, win/lose) and the LED / seven-segment display path.
// PARAMETERS
//  SYNC_STAGES  2          flops in each input synchroniser (>=2)
//  STABLE_CNT   2          consecutive identical legal samples required to commit a frame (1..7)
//  TIMEOUT_CYC  4000000    clk cycles without a sync edge before the link is declared lost
// PORTS
//  clk               in   1  system clock
//  pb_in_rst         in   1  synchronous reset, active-low
//  con_in_clk_sync   in   1  remote frame strobe, async; a frame is sampled on its rising edge
//  con_in_stat       in   3  remote status, async
//  con_in_score      in   7  remote score, async
//  con_in_ko         in   3  remote KO count (mod 8), async
//  con_in_bomb       in   1  remote bomb level, async
//  opp_stat          out  3  committed status
//  opp_score         out  7  committed score
//  opp_ko            out  3  committed KO count
//  frame_commit      out  1  1-cycle pulse when a frame is committed
//  bomb_evt          out  1  1-cycle pulse: committed bomb went 0->1
//  ko_evt            out  1  1-cycle pulse: committed KO advanced by exactly +1 (mod 8)
//  link_up           out  1  high while FSM is LINKED
// BEHAVIOUR
//  - Reset (pb_in_rst==0 at a clk edge): all outputs 0; FSM=DOWN; counters, sample and synchroniser regs cleared.
//    Reset mid-frame discards any partial qualification.
//  - Synchronisation: each con_in_* bit passes through SYNC_STAGES flops.
//    Strobe edge = synced strobe 1 while previous synced value 0. Edge seen SYNC_STAGES+1 cycles after the pin rises.
//  - Sample: on an edge, capture {stat,score,ko,bomb} (14 b).
//    Illegal = stat in 5..7 (reserved); an illegal sample forces stable count to 0.
//    A legal sample equal to the previous sample increments the stable count (saturates at STABLE_CNT).
//    A legal sample that differs sets the stable count to 1.
//  - Commit: on the cycle the stable count reaches STABLE_CNT with a value differing from the committed one, or on the first commit after DOWN/ACQUIRE:
//    - opp_* update on the next edge.
//    - frame_commit pulses on the same cycle.
//    Latency: pin to output = SYNC_STAGES+2 clk after the qualifying strobe edge.
//  - Events, evaluated against the previously committed frame:
//    - bomb_evt when bomb goes 0->1.
//    - ko_evt when new_ko == old_ko+1 mod 8 (7->0 counts). Other KO jumps update opp_ko silently.
//    - No events on the first commit after entering LINKED.
//  - Watchdog counter:
//    - Clears on every strobe edge; otherwise increments, saturating.
//    - Reaching TIMEOUT_CYC forces DOWN.
//    - An edge in the same cycle as expiry wins: counter clears, FSM stays.
//  - FSM:
//    - DOWN    -> ACQUIRE  on first strobe edge.
//    - ACQUIRE -> LINKED   on first commit.
//    - ACQUIRE -> DOWN     on timeout.
//    - LINKED  -> DOWN     on timeout.
//    - Entering DOWN clears opp_*, link_up and the stable count.
//  - Pulses never assert while in DOWN; at most one commit per strobe edge.
// CONFIGURATION
//  Macro LINK_RX_SCORE_CLAMP_EN.
//  - Defined: a committed score >99 is stored as 99, for the two-digit seven-segment display.
//    Equality for frame_commit is evaluated on the raw 7-bit score.
//  - Undefined: opp_score carries the raw 0..127 value.
// STRUCTURE
//  - Shared package tetris_pkg:
//    - STAT_IDLE=0, STAT_READY=1, STAT_PLAY=2, STAT_PAUSE=3, STAT_OVER=4.
//    - LINK_FRAME_W=14.
//    - FSM state encodings DOWN/ACQUIRE/LINKED.
//  - Sub-module link_sync: a 1-bit SYNC_STAGES-deep synchroniser, instantiated 15 times.
//  - Watchdog counter width = $clog2(TIMEOUT_CYC+1).
// TESTING
//  1. Reset held with random pins -> all outputs 0. Release with no strobe -> link_up stays 0.
//  2. Strobe 2x with stat=2, score=37, ko=0, bomb=0:
//     - frame_commit once, SYNC_STAGES+2 cycles after the 2nd edge.
//     - opp_score=37 and link_up=1.
//     - No bomb_evt and no ko_evt.
//  3. Linked; frames bomb=1 x2 -> bomb_evt single pulse. Then ko 7->0 x2 -> ko_evt pulse, opp_ko=0.
//     Then ko 0->3 -> no ko_evt, opp_ko=3.
//  4. Alternating samples score 10/11 -> no commit. stat=6 x3 -> no commit, count held at 0.
//  5. Linked, then stop the strobe for TIMEOUT_CYC cycles:
//     - link_up=0 and opp_* = 0.
//     - Strobe arriving on the expiry cycle keeps link_up=1.
//  6. Score=120 committed -> opp_score=120 without the macro, 99 with LINK_RX_SCORE_CLAMP_EN.
//     Pulse pb_in_rst low mid-qualification -> no commit from pre-reset samples.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the battle link: status codes, frame layout,
// link FSM states and the score clamp helper used by the display path.
package tetris_pkg;

    localparam logic [2:0] STAT_IDLE  = 3'd0;
    localparam logic [2:0] STAT_READY = 3'd1;
    localparam logic [2:0] STAT_PLAY  = 3'd2;
    localparam logic [2:0] STAT_PAUSE = 3'd3;
    localparam logic [2:0] STAT_OVER  = 3'd4;

    localparam int LINK_FRAME_W = 14;

    typedef enum logic [1:0] {
        LINK_DOWN    = 2'd0,
        LINK_ACQUIRE = 2'd1,
        LINK_LINKED  = 2'd2
    } link_state_t;

    typedef struct packed {
        logic [2:0] stat;
        logic [6:0] score;
        logic [2:0] ko;
        logic       bomb;
    } link_frame_t;

    // Codes 5..7 are reserved and mark a frame as illegal.
    function automatic logic stat_legal(input logic [2:0] s);
        return s inside {STAT_IDLE, STAT_READY, STAT_PLAY, STAT_PAUSE, STAT_OVER};
    endfunction

    function automatic logic [6:0] clamp_score(input logic [6:0] s);
        return (s > 7'd99) ? 7'd99 : s;
    endfunction

endpackage

// File: rtl/battle_link_rx_if.sv
// Opponent connector bus as seen by the receive stage.
interface battle_link_rx_if;

    logic       con_in_clk_sync;
    logic [2:0] con_in_stat;
    logic [6:0] con_in_score;
    logic [2:0] con_in_ko;
    logic       con_in_bomb;

    modport master (
        output con_in_clk_sync, con_in_stat, con_in_score, con_in_ko, con_in_bomb
    );

    modport slave (
        input con_in_clk_sync, con_in_stat, con_in_score, con_in_ko, con_in_bomb
    );

endinterface

// File: rtl/link_sync.sv
// Single-bit multi-flop synchroniser for one asynchronous connector pin.
module link_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic pb_in_rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the pin through the flop chain; cleared by reset.
    always_ff @(posedge clk) begin
        if (!pb_in_rst) chain <= '0;
        else            chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/battle_link_rx.sv
// Battle link receive stage: synchronises the opponent bus, qualifies frames
// on strobe edges, commits stable legal frames and raises bomb/KO events.
// Optional build macro LINK_RX_SCORE_CLAMP_EN clamps the displayed score to 99.
module battle_link_rx
    import tetris_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 2,
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic             clk,
    input  logic             pb_in_rst,
    battle_link_rx_if.slave  con,
    output logic [2:0]       opp_stat,
    output logic [6:0]       opp_score,
    output logic [2:0]       opp_ko,
    output logic             frame_commit,
    output logic             bomb_evt,
    output logic             ko_evt,
    output logic             link_up
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [2:0]      STB_MAX = 3'(STABLE_CNT);

    logic [LINK_FRAME_W:0] pins;
    logic [LINK_FRAME_W:0] synced;
    link_frame_t           frame_in;
    logic                  strobe_s;
    logic                  strobe_q;
    logic                  strb_edge;

    link_frame_t           samp;
    logic                  samp_new;
    logic [2:0]            stab_cnt;
    logic [2:0]            stab_nxt;
    link_frame_t           cmt;
    logic [WD_W-1:0]       wdog;
    logic                  timeout;
    logic                  commit;
    logic                  enter_down;

    link_state_t           state;
    link_state_t           state_nxt;

    assign pins = {con.con_in_clk_sync, con.con_in_stat, con.con_in_score,
                   con.con_in_ko, con.con_in_bomb};

    for (genvar i = 0; i <= LINK_FRAME_W; i++) begin : g_sync
        link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk       (clk),
            .pb_in_rst (pb_in_rst),
            .d         (pins[i]),
            .q         (synced[i])
        );
    end

    assign frame_in = link_frame_t'(synced[LINK_FRAME_W-1:0]);
    assign strobe_s = synced[LINK_FRAME_W];

    // Edge detect, stability count update, commit and watchdog expiry decisions.
    always_comb begin
        strb_edge = strobe_s & ~strobe_q;
        stab_nxt  = stab_cnt;
        if (!stat_legal(frame_in.stat))
            stab_nxt = '0;
        else if (frame_in == samp)
            stab_nxt = (stab_cnt >= STB_MAX) ? STB_MAX : stab_cnt + 3'd1;
        else
            stab_nxt = 3'd1;
        // An edge on the expiry cycle restarts the watchdog instead of dropping the link.
        timeout    = (wdog == WD_MAX) && !strb_edge;
        enter_down = timeout && (state != LINK_DOWN);
        // samp_new limits evaluation to the cycle after each captured sample.
        commit     = samp_new && (state != LINK_DOWN) && (stab_cnt == STB_MAX) &&
                     ((state == LINK_ACQUIRE) || (samp != cmt));
    end

    // Link FSM state register.
    always_ff @(posedge clk) begin
        if (!pb_in_rst) state <= LINK_DOWN;
        else            state <= state_nxt;
    end

    // Link FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            LINK_DOWN:    if (strb_edge) state_nxt = LINK_ACQUIRE;
            LINK_ACQUIRE: if (timeout)   state_nxt = LINK_DOWN;
                          else if (commit) state_nxt = LINK_LINKED;
            LINK_LINKED:  if (timeout)   state_nxt = LINK_DOWN;
            default:      state_nxt = LINK_DOWN;
        endcase
    end

    // Link FSM outputs and committed-frame presentation.
    always_comb begin
        link_up  = (state == LINK_LINKED);
        opp_stat = cmt.stat;
        opp_ko   = cmt.ko;
`ifdef LINK_RX_SCORE_CLAMP_EN
        opp_score = clamp_score(cmt.score);
`else
        opp_score = cmt.score;
`endif
    end

    // Sample capture, qualification, commit registers, event pulses and watchdog.
    always_ff @(posedge clk) begin
        if (!pb_in_rst) begin
            strobe_q     <= 1'b0;
            samp         <= '0;
            samp_new     <= 1'b0;
            stab_cnt     <= '0;
            cmt          <= '0;
            wdog         <= '0;
            frame_commit <= 1'b0;
            bomb_evt     <= 1'b0;
            ko_evt       <= 1'b0;
        end else begin
            strobe_q     <= strobe_s;
            samp_new     <= strb_edge;
            frame_commit <= commit;
            bomb_evt     <= commit && (state == LINK_LINKED) && samp.bomb && !cmt.bomb;
            ko_evt       <= commit && (state == LINK_LINKED) && (samp.ko == cmt.ko + 3'd1);

            if (strb_edge)          wdog <= '0;
            else if (wdog != WD_MAX) wdog <= wdog + WD_ONE;

            if (strb_edge) begin
                samp     <= frame_in;
                stab_cnt <= stab_nxt;
            end else if (enter_down) begin
                stab_cnt <= '0;
            end

            if (enter_down)  cmt <= '0;
            else if (commit) cmt <= samp;
        end
    end

endmodule
